// File: rtl/regfile_arb_pkg.sv
// Shared types and the round-robin search helper for the register-file arbiter.
package regfile_arb_pkg;

  // Arbitration state: open round-robin or held by a locked owner.
  typedef enum logic {ARB = 1'b0, LOCKED = 1'b1} arb_state_t;

  // Largest requester count the round-robin helper can search.
  localparam int unsigned RR_MAXN = 16;
  localparam int unsigned RR_IDXW = 4;

  // Returns the index of the first set mask bit scanning from ptr+1 (mod n).
  // When no bit is set the result is ptr; callers qualify it with |mask.
  function automatic int unsigned rr_next(input logic [RR_MAXN-1:0] mask,
                                          input int unsigned ptr,
                                          input int unsigned n);
    int unsigned idx;
    int unsigned win;
    logic        found;
    win   = ptr;
    found = 1'b0;
    for (int unsigned k = 1; k <= RR_MAXN; k++) begin
      idx = ptr + k;
      if (idx >= n) begin
        idx = idx - n;
      end else begin
        idx = idx;
      end
      if (!found && (k <= n) && mask[idx[RR_IDXW-1:0]]) begin
        win   = idx;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/regfile_arbiter_rr_picker.sv
// Combinational round-robin picker: one-hot grant from a request mask,
// searching upward from the position after the pointer.
module rr_picker
  import regfile_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDXW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_mask,
  input  logic [IDXW-1:0] i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IDXW-1:0] o_idx,
  output logic            o_any
);

  logic [RR_MAXN-1:0] w_mask_pad;
  logic [IDXW-1:0]    w_idx;
  logic               w_any;

  // Widen the request mask to the helper's fixed search width.
  always_comb begin
    w_mask_pad             = {RR_MAXN{1'b0}};
    w_mask_pad[NREQ-1:0]   = i_mask;
  end

  // Pick the winner and decode it to a one-hot grant.
  always_comb begin
    w_any = |i_mask;
    w_idx = IDXW'(rr_next(w_mask_pad, int'(i_ptr), NREQ));
    o_gnt = {NREQ{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      o_gnt[i] = w_any & (w_idx == IDXW'(i));
    end
    o_idx = w_idx;
    o_any = w_any;
  end

endmodule

// File: rtl/regfile_arbiter.sv
// Register-file access arbiter: shares the write port and read port 1 between
// NREQ requesters with round-robin grant, optional locked ownership bounded by
// MAXLOCK grants, and a registered one-cycle read response.
module regfile_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int REGBITS = 3,
  parameter int NREQ    = 2,
  parameter int MAXLOCK = 4
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [NREQ-1:0]         i_req_valid,
  output logic [NREQ-1:0]         o_req_ready,
  input  logic [NREQ-1:0]         i_req_we,
  input  logic [NREQ-1:0]         i_req_lock,
  input  logic [NREQ*REGBITS-1:0] i_req_addr,
  input  logic [NREQ*WIDTH-1:0]   i_req_wdata,
  output logic [NREQ-1:0]         o_rsp_valid,
  output logic [WIDTH-1:0]        o_rsp_data,
  output logic                    o_rf_regwrite,
  output logic [REGBITS-1:0]      o_rf_wa,
  output logic [WIDTH-1:0]        o_rf_wd,
  output logic [REGBITS-1:0]      o_rf_ra,
  input  logic [WIDTH-1:0]        i_rf_rd
);

  localparam int IDXW = $clog2(NREQ);
  localparam int CNTW = $clog2(MAXLOCK + 1);

  arb_state_t        r_state;
  arb_state_t        w_state_next;
  logic [IDXW-1:0]   r_owner;
  logic [IDXW-1:0]   r_rr_ptr;
  logic [CNTW-1:0]   r_lock_cnt;
  logic [NREQ-1:0]   r_rsp_valid;
  logic [WIDTH-1:0]  r_rsp_data;

  logic [NREQ-1:0]    w_mask;
  logic [NREQ-1:0]    w_gnt;
  logic [IDXW-1:0]    w_idx;
  logic               w_xfer;
  logic               w_we;
  logic               w_lock;
  logic [REGBITS-1:0] w_addr;
  logic [WIDTH-1:0]   w_wdata;
  logic               w_owner_valid;
  logic [CNTW-1:0]    w_cnt_inc;
  logic               w_force;

  // Eligible requests: everyone in ARB, only the owner while LOCKED.
  always_comb begin
    w_mask = {NREQ{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      w_mask[i] = i_req_valid[i] & ((r_state == ARB) || (r_owner == IDXW'(i)));
    end
  end

  rr_picker #(.NREQ(NREQ), .IDXW(IDXW)) u_picker (
    .i_mask (w_mask),
    .i_ptr  (r_rr_ptr),
    .o_gnt  (w_gnt),
    .o_idx  (w_idx),
    .o_any  (w_xfer)
  );

  // Select the winning requester's command fields and lock bookkeeping.
  // lock_cnt counts grants already taken in the current locked run, so the
  // grant that brings it to MAXLOCK is the last one before forced release.
  always_comb begin
    w_we          = i_req_we[w_idx];
    w_lock        = i_req_lock[w_idx];
    w_addr        = i_req_addr[w_idx*REGBITS +: REGBITS];
    w_wdata       = i_req_wdata[w_idx*WIDTH +: WIDTH];
    w_owner_valid = i_req_valid[r_owner];
    w_cnt_inc     = r_lock_cnt + CNTW'(1);
    if (r_state == LOCKED) begin
      w_force = (w_cnt_inc >= CNTW'(MAXLOCK));
    end else begin
      w_force = (MAXLOCK <= 1);
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ARB;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic for locked ownership.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ARB: begin
        if (w_xfer && w_lock && !w_force) begin
          w_state_next = LOCKED;
        end else begin
          w_state_next = ARB;
        end
      end
      LOCKED: begin
        if (!w_owner_valid) begin
          w_state_next = ARB;
        end else if (w_xfer && (!w_lock || w_force)) begin
          w_state_next = ARB;
        end else begin
          w_state_next = LOCKED;
        end
      end
      default: w_state_next = ARB;
    endcase
  end

  // Output logic: grant and register-file port drive for the current beat.
  always_comb begin
    o_req_ready   = w_gnt;
    o_rf_regwrite = 1'b0;
    o_rf_wa       = {REGBITS{1'b0}};
    o_rf_wd       = {WIDTH{1'b0}};
    o_rf_ra       = {REGBITS{1'b0}};
    if (w_xfer && w_we) begin
      o_rf_regwrite = (w_addr != {REGBITS{1'b0}});
      o_rf_wa       = w_addr;
      o_rf_wd       = w_wdata;
    end else if (w_xfer) begin
      o_rf_ra       = w_addr;
    end else begin
      o_rf_ra       = {REGBITS{1'b0}};
    end
  end

  // Owner, lock counter and round-robin pointer; the pointer follows every transfer.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_owner    <= {IDXW{1'b0}};
      r_lock_cnt <= {CNTW{1'b0}};
      r_rr_ptr   <= IDXW'(NREQ - 1);
    end else begin
      if (w_xfer) begin
        r_rr_ptr <= w_idx;
      end
      if (w_state_next == ARB) begin
        r_lock_cnt <= {CNTW{1'b0}};
      end else if (r_state == ARB) begin
        r_owner    <= w_idx;
        r_lock_cnt <= CNTW'(1);
      end else if (w_xfer) begin
        r_lock_cnt <= w_cnt_inc;
      end
    end
  end

  // Read response register: capture read data one cycle after a read grant.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rsp_valid <= {NREQ{1'b0}};
      r_rsp_data  <= {WIDTH{1'b0}};
    end else if (w_xfer && !w_we) begin
      r_rsp_valid <= w_gnt;
      r_rsp_data  <= i_rf_rd;
    end else begin
      r_rsp_valid <= {NREQ{1'b0}};
    end
  end

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Self-checking bench for regfile_arbiter: per-cycle grant checks plus a
// response scoreboard fed when reads are issued and drained one cycle later.
module tb_regfile_arbiter;

  localparam int WIDTH   = 8;
  localparam int REGBITS = 3;
  localparam int NREQ    = 2;
  localparam int MAXLOCK = 4;

  typedef struct packed {
    logic [NREQ-1:0]  mask;
    logic [WIDTH-1:0] data;
  } rsp_t;

  logic                    clk;
  logic                    reset;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ-1:0]         req_we;
  logic [NREQ-1:0]         req_lock;
  logic [NREQ*REGBITS-1:0] req_addr;
  logic [NREQ*WIDTH-1:0]   req_wdata;
  logic [NREQ-1:0]         rsp_valid;
  logic [WIDTH-1:0]        rsp_data;
  logic                    rf_regwrite;
  logic [REGBITS-1:0]      rf_wa;
  logic [WIDTH-1:0]        rf_wd;
  logic [REGBITS-1:0]      rf_ra;
  logic [WIDTH-1:0]        rf_rd;

  logic [WIDTH-1:0] rf_mem  [8];
  logic [WIDTH-1:0] exp_rf  [8];
  rsp_t             rsp_q   [$];
  int               n_checks;
  int               n_errors;

  regfile_arbiter #(.WIDTH(WIDTH), .REGBITS(REGBITS), .NREQ(NREQ), .MAXLOCK(MAXLOCK)) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_req_valid   (req_valid),
    .o_req_ready   (req_ready),
    .i_req_we      (req_we),
    .i_req_lock    (req_lock),
    .i_req_addr    (req_addr),
    .i_req_wdata   (req_wdata),
    .o_rsp_valid   (rsp_valid),
    .o_rsp_data    (rsp_data),
    .o_rf_regwrite (rf_regwrite),
    .o_rf_wa       (rf_wa),
    .o_rf_wd       (rf_wd),
    .o_rf_ra       (rf_ra),
    .i_rf_rd       (rf_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model behind the arbiter.
  always_ff @(posedge clk) begin
    if (rf_regwrite) rf_mem[rf_wa] <= rf_wd;
  end
  assign rf_rd = rf_mem[rf_ra];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Compare the registered response against the scoreboard head (or idle).
  task automatic check_rsp();
    rsp_t e;
    if (rsp_q.size() > 0) begin
      e = rsp_q.pop_front();
      check_eq("rsp_valid", 32'(rsp_valid), 32'(e.mask));
      check_eq("rsp_data", 32'(rsp_data), 32'(e.data));
    end else begin
      check_eq("rsp_idle", 32'(rsp_valid), 32'd0);
    end
  endtask

  // One bus cycle: drive, check grant and write enable, update expectations.
  task automatic cyc(input logic rst, input logic [1:0] v, input logic [1:0] we,
                     input logic [1:0] lk, input logic [2:0] a0, input logic [2:0] a1,
                     input logic [7:0] d0, input logic [7:0] d1, input logic [1:0] exp_rdy);
    int          g;
    logic [2:0]  ga;
    logic [7:0]  gd;
    logic        exp_wr;
    rsp_t        e;
    @(negedge clk);
    check_rsp();
    reset     = rst;
    req_valid = v;
    req_we    = we;
    req_lock  = lk;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
    #1;
    check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
    g      = exp_rdy[1] ? 1 : 0;
    ga     = (g == 1) ? a1 : a0;
    gd     = (g == 1) ? d1 : d0;
    exp_wr = (exp_rdy != 2'b00) && we[g] && (ga != 3'd0);
    check_eq("rf_regwrite", 32'(rf_regwrite), 32'(exp_wr));
    if (!rst && exp_rdy != 2'b00) begin
      if (we[g]) begin
        if (ga != 3'd0) exp_rf[ga] = gd;
      end else begin
        e.mask = exp_rdy;
        e.data = exp_rf[ga];
        rsp_q.push_back(e);
      end
    end
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    for (int i = 0; i < 8; i++) begin
      rf_mem[i] = 8'h00;
      exp_rf[i] = 8'h00;
    end
    reset     = 1'b1;
    req_valid = 2'b00;
    req_we    = 2'b00;
    req_lock  = 2'b00;
    req_addr  = '0;
    req_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("reset_rsp_data", 32'(rsp_data), 32'd0);
    check_eq("reset_ready", 32'(req_ready), 32'd0);
    check_eq("reset_regwrite", 32'(rf_regwrite), 32'd0);

    // Write then read back through req0.
    cyc(1'b0, 2'b01, 2'b01, 2'b00, 3'd3, 3'd0, 8'h5A, 8'h00, 2'b01);
    cyc(1'b0, 2'b01, 2'b00, 2'b00, 3'd3, 3'd0, 8'h00, 8'h00, 2'b01);
    cyc(1'b0, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b00);

    // Write to r0 is suppressed; read of r0 returns zero.
    cyc(1'b0, 2'b10, 2'b10, 2'b00, 3'd0, 3'd0, 8'h00, 8'hFF, 2'b10);
    cyc(1'b0, 2'b10, 2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b10);
    cyc(1'b0, 2'b10, 2'b10, 2'b00, 3'd0, 3'd5, 8'h00, 8'hC3, 2'b10);

    // Two competing unlocked readers alternate.
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 2'b11, 2'b00, 2'b00, 3'd3, 3'd5, 8'h00, 8'h00, (i % 2 == 0) ? 2'b01 : 2'b10);
    end

    // Locked req0 is cut off after MAXLOCK grants, req1 gets one, then req0 again.
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 2'b11, 2'b00, 2'b01, 3'd5, 3'd3, 8'h00, 8'h00, (i == 4) ? 2'b10 : 2'b01);
    end

    // Owner drops valid: nobody granted that cycle, req1 the next.
    cyc(1'b0, 2'b10, 2'b00, 2'b00, 3'd0, 3'd3, 8'h00, 8'h00, 2'b00);
    cyc(1'b0, 2'b10, 2'b00, 2'b00, 3'd0, 3'd3, 8'h00, 8'h00, 2'b10);

    // Reset while locked with a read being granted.
    cyc(1'b0, 2'b01, 2'b00, 2'b01, 3'd3, 3'd0, 8'h00, 8'h00, 2'b01);
    cyc(1'b1, 2'b01, 2'b00, 2'b01, 3'd3, 3'd0, 8'h00, 8'h00, 2'b01);
    rsp_q.delete();
    cyc(1'b0, 2'b11, 2'b00, 2'b00, 3'd5, 3'd3, 8'h00, 8'h00, 2'b01);
    check_eq("post_reset_rsp_data", 32'(rsp_data), 32'd0);
    cyc(1'b0, 2'b11, 2'b00, 2'b00, 3'd5, 3'd3, 8'h00, 8'h00, 2'b10);
    cyc(1'b0, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b00);
    cyc(1'b0, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b00);
    check_eq("scoreboard_drained", 32'(rsp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
